// File: rtl/fixed_float_pkg.sv
// ---------------------------------------------------------------------------
// fixed_float_pkg
// Shared constants and types for the fixed-to-float return path.
//   FIX_W    : width of the sign-magnitude fixed-point input {sign, int, frac}
//   FRAC_W   : fractional bits of the fixed-point input
//   MAG_W    : magnitude width (integer bit + fraction)
//   CNT_W    : width of the leading-zero / shift counter
//   FLT_W    : IEEE-754 single-precision width
//   EXP_BIAS : exponent of a value whose leading one sits in the integer bit
// ---------------------------------------------------------------------------
package fixed_float_pkg;

  localparam int FIX_W  = 22;
  localparam int FRAC_W = 20;
  localparam int MAG_W  = FRAC_W + 1;
  localparam int CNT_W  = 5;
  localparam int FLT_W  = 32;

  localparam logic [7:0] EXP_BIAS = 8'd127;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_e;

  // Assemble a normal single from a magnitude whose MSB is already the hidden
  // one. lz is the number of places the magnitude was shifted up, so the
  // exponent is the bias minus that shift. The 20 fraction bits fill the top
  // of the 23-bit mantissa field exactly, so no rounding is ever needed.
  function automatic logic [FLT_W-1:0] pack_float(
    input logic             sign,
    input logic [CNT_W-1:0] lz,
    input logic [MAG_W-1:0] mag_n
  );
    logic [7:0] exp_f;
    exp_f = EXP_BIAS - {3'b000, lz};
    return {sign, exp_f, mag_n[FRAC_W-1:0], 3'b000};
  endfunction

endpackage

// File: rtl/fixed_float_conversion_lod.sv
// ---------------------------------------------------------------------------
// leading_one_detect
// Combinational leading-zero count of the 21-bit magnitude. Used by the
// single-cycle normalizer build (FIXED_FLOAT_FAST_NORM_EN).
//   vec : magnitude to inspect
//   lz  : number of zeros above the most significant set bit (0..20);
//         0 when vec is all zeros (the zero case is flagged separately)
// ---------------------------------------------------------------------------
module leading_one_detect
  import fixed_float_pkg::*;
(
  input  logic [MAG_W-1:0] vec,
  output logic [CNT_W-1:0] lz
);

  // Scan upward; the highest set bit is the last one to write lz.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (vec[i]) begin
        lz = CNT_W'(MAG_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fixed_float_conversion.sv
// ---------------------------------------------------------------------------
// fixed_float_conversion
// Repacks a 22-bit sign-magnitude fixed-point value (1 sign, 1 integer,
// 20 fraction bits) as an IEEE-754 single. The default build normalizes by
// shifting the magnitude up one place per cycle until its MSB is set; the
// latency is 1 + (leading zeros of the magnitude).
//
// Build option:
//   FIXED_FLOAT_FAST_NORM_EN : a combinational leading-one detector
//     pre-normalizes the magnitude at capture, so every conversion finishes
//     on the first NORM cycle (latency 1). Results are bit-identical.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : conversion request, sampled only while idle
//   data   : {sign, int bit, 20 frac bits}, captured on the accepted start
//   busy   : high while a conversion is in progress (start ignored)
//   done   : one-cycle completion pulse
//   result : IEEE-754 single, held until the next completion
// ---------------------------------------------------------------------------
module fixed_float_conversion
  import fixed_float_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FIX_W-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [FLT_W-1:0] result
);

  state_e           state;
  logic             sign_r;
  logic [MAG_W-1:0] mag_r;
  logic [CNT_W-1:0] cnt_r;
  logic             zero_r;

  logic [MAG_W-1:0] mag_in;
  logic [CNT_W-1:0] lz_in;
  logic [MAG_W-1:0] mag_cap;

  assign mag_in = data[MAG_W-1:0];

`ifdef FIXED_FLOAT_FAST_NORM_EN
  // Pre-normalize at capture: the loaded magnitude already has its leading
  // one in the MSB and the counter already holds the shift, so NORM takes
  // the finalize branch on its first cycle.
  leading_one_detect u_lod (
    .vec (mag_in),
    .lz  (lz_in)
  );
  assign mag_cap = mag_in << lz_in;
`else
  // Iterative build: load the raw magnitude and let NORM shift it.
  assign lz_in   = '0;
  assign mag_cap = mag_in;
`endif

  // Capture (IDLE) -> normalize/finalize (NORM)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      mag_r  <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_r <= data[FIX_W-1];
            mag_r  <= mag_cap;
            cnt_r  <= lz_in;
            zero_r <= (mag_in == '0);
            busy   <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          if (zero_r) begin
            // Zero magnitude would never normalize; emit a signed zero.
            result <= {sign_r, {(FLT_W-1){1'b0}}};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (mag_r[MAG_W-1]) begin
            result <= pack_float(sign_r, cnt_r, mag_r);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            // At most 20 shifts, so the 5-bit counter never wraps.
            mag_r <= mag_r << 1;
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
